// File: rtl/seven_seg_scan_ctrl.sv
// Multiplexed N-digit seven-segment scan controller with PWM dimming,
// leading-zero suppression and frame-aligned double-buffered display data.
module seven_seg_scan_ctrl #(
    parameter int unsigned NUM_DIGITS       = 8,
    parameter int unsigned CLK_DIV          = 100000,
    parameter bit          ANODE_ACTIVE_LOW = 1'b1,
    parameter bit          SEG_ACTIVE_LOW   = 1'b1
) (
    input  logic                    clk,
    input  logic                    clr,
    input  logic [4*NUM_DIGITS-1:0] digits,
    input  logic [NUM_DIGITS-1:0]   dp,
    input  logic [NUM_DIGITS-1:0]   blank,
    input  logic                    lz_suppress,
    input  logic [3:0]              brightness,
    input  logic                    load,
    output logic                    ready,
    output logic                    frame_tick,
    output logic [NUM_DIGITS-1:0]   AN,
    output logic [6:0]              CA,
    output logic                    DP
);

    localparam int unsigned CNT_W    = $clog2(CLK_DIV);
    localparam int unsigned IDX_W    = $clog2(NUM_DIGITS);
    localparam int unsigned DAT_W    = 4 * NUM_DIGITS;
    localparam int unsigned PWM_STEP = CLK_DIV / 16;

    localparam logic [NUM_DIGITS-1:0] AN_OFF = ANODE_ACTIVE_LOW ? '1 : '0;
    localparam logic [6:0]            CA_OFF = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
    localparam logic                  DP_OFF = SEG_ACTIVE_LOW;

    // Hex to segments, bit order gfedcba, active-high
    function automatic logic [6:0] hex_to_seg(input logic [3:0] v);
        case (v)
            4'h0: hex_to_seg = 7'h3F;
            4'h1: hex_to_seg = 7'h06;
            4'h2: hex_to_seg = 7'h5B;
            4'h3: hex_to_seg = 7'h4F;
            4'h4: hex_to_seg = 7'h66;
            4'h5: hex_to_seg = 7'h6D;
            4'h6: hex_to_seg = 7'h7D;
            4'h7: hex_to_seg = 7'h07;
            4'h8: hex_to_seg = 7'h7F;
            4'h9: hex_to_seg = 7'h6F;
            4'hA: hex_to_seg = 7'h77;
            4'hB: hex_to_seg = 7'h7C;
            4'hC: hex_to_seg = 7'h39;
            4'hD: hex_to_seg = 7'h5E;
            4'hE: hex_to_seg = 7'h79;
            default: hex_to_seg = 7'h71;
        endcase
    endfunction

    logic [CNT_W-1:0]      slot_q, slot_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic                  valid_q, valid_d;
    logic [DAT_W-1:0]      pend_dig_q, pend_dig_d;
    logic [NUM_DIGITS-1:0] pend_dp_q, pend_dp_d;
    logic [NUM_DIGITS-1:0] pend_blank_q, pend_blank_d;
    logic                  pend_lz_q, pend_lz_d;
    logic [DAT_W-1:0]      act_dig_q, act_dig_d;
    logic [NUM_DIGITS-1:0] act_dp_q, act_dp_d;
    logic [NUM_DIGITS-1:0] act_blank_q, act_blank_d;
    logic                  act_lz_q, act_lz_d;
    logic                  ready_q, ready_d;
    logic                  tick_q, tick_d;
    logic [NUM_DIGITS-1:0] an_q, an_d;
    logic [6:0]            ca_q, ca_d;
    logic                  dp_q, dp_d;

    logic                  slot_wrap_c;
    logic                  frame_wrap_c;
    logic [3:0]            nib_c [NUM_DIGITS];
    logic [NUM_DIGITS-1:0] lz_dark_c;
    logic                  zero_run_c;
    logic [CNT_W:0]        pwm_lim_c;
    logic                  pwm_on_c;
    logic                  seg_on_c;
    logic                  dp_on_c;
    logic [NUM_DIGITS-1:0] an_raw_c;
    logic [6:0]            seg_raw_c;

    // Scan counters and load/commit handshake
    always_comb begin
        slot_d       = slot_q + CNT_W'(1);
        idx_d        = idx_q;
        valid_d      = valid_q;
        pend_dig_d   = pend_dig_q;
        pend_dp_d    = pend_dp_q;
        pend_blank_d = pend_blank_q;
        pend_lz_d    = pend_lz_q;
        act_dig_d    = act_dig_q;
        act_dp_d     = act_dp_q;
        act_blank_d  = act_blank_q;
        act_lz_d     = act_lz_q;

        slot_wrap_c  = (slot_q == CNT_W'(CLK_DIV - 1));
        frame_wrap_c = slot_wrap_c && (idx_q == IDX_W'(NUM_DIGITS - 1));

        if (slot_wrap_c) begin
            slot_d = '0;
            idx_d  = frame_wrap_c ? '0 : idx_q + IDX_W'(1);
        end

        if (frame_wrap_c && valid_q) begin
            act_dig_d   = pend_dig_q;
            act_dp_d    = pend_dp_q;
            act_blank_d = pend_blank_q;
            act_lz_d    = pend_lz_q;
            valid_d     = 1'b0;
        end

        // Pending slot only accepts data while empty; a same-edge commit cannot occur then
        if (load && !valid_q) begin
            pend_dig_d   = digits;
            pend_dp_d    = dp;
            pend_blank_d = blank;
            pend_lz_d    = lz_suppress;
            valid_d      = 1'b1;
        end

        ready_d = !valid_d;
        tick_d  = frame_wrap_c;
    end

    // Digit selection, suppression, PWM gating and output polarity
    always_comb begin
        zero_run_c = 1'b1;
        lz_dark_c  = '0;
        for (int i = int'(NUM_DIGITS) - 1; i >= 0; i--) begin
            nib_c[i]     = act_dig_q[4*i +: 4];
            zero_run_c   = zero_run_c && (nib_c[i] == 4'h0);
            lz_dark_c[i] = act_lz_q && zero_run_c && (i != 0);
        end

        pwm_lim_c = (CNT_W + 1)'((32'(brightness) + 32'd1) * PWM_STEP);
        pwm_on_c  = ({1'b0, slot_q} < pwm_lim_c);

        seg_on_c = pwm_on_c && !act_blank_q[idx_q] && !lz_dark_c[idx_q];
        dp_on_c  = pwm_on_c && !act_blank_q[idx_q] && act_dp_q[idx_q];

        an_raw_c = '0;
        if (seg_on_c || dp_on_c) begin
            an_raw_c[idx_q] = 1'b1;
        end
        seg_raw_c = seg_on_c ? hex_to_seg(nib_c[idx_q]) : 7'h00;

        an_d = ANODE_ACTIVE_LOW ? ~an_raw_c : an_raw_c;
        ca_d = SEG_ACTIVE_LOW ? ~seg_raw_c : seg_raw_c;
        dp_d = SEG_ACTIVE_LOW ? ~dp_on_c : dp_on_c;
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            slot_q       <= '0;
            idx_q        <= '0;
            valid_q      <= 1'b0;
            pend_dig_q   <= '0;
            pend_dp_q    <= '0;
            pend_blank_q <= '1;
            pend_lz_q    <= 1'b0;
            act_dig_q    <= '0;
            act_dp_q     <= '0;
            act_blank_q  <= '1;
            act_lz_q     <= 1'b0;
            ready_q      <= 1'b1;
            tick_q       <= 1'b0;
            an_q         <= AN_OFF;
            ca_q         <= CA_OFF;
            dp_q         <= DP_OFF;
        end else begin
            slot_q       <= slot_d;
            idx_q        <= idx_d;
            valid_q      <= valid_d;
            pend_dig_q   <= pend_dig_d;
            pend_dp_q    <= pend_dp_d;
            pend_blank_q <= pend_blank_d;
            pend_lz_q    <= pend_lz_d;
            act_dig_q    <= act_dig_d;
            act_dp_q     <= act_dp_d;
            act_blank_q  <= act_blank_d;
            act_lz_q     <= act_lz_d;
            ready_q      <= ready_d;
            tick_q       <= tick_d;
            an_q         <= an_d;
            ca_q         <= ca_d;
            dp_q         <= dp_d;
        end
    end

    assign ready      = ready_q;
    assign frame_tick = tick_q;
    assign AN         = an_q;
    assign CA         = ca_q;
    assign DP         = dp_q;

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Directed bench for seven_seg_scan_ctrl: 4 digits, 16 clocks per slot, active-low pins.
module tb_seven_seg_scan_ctrl;

    logic        clk = 1'b0;
    logic        clr;
    logic [15:0] digits;
    logic [3:0]  dp;
    logic [3:0]  blank;
    logic        lz_suppress;
    logic [3:0]  brightness;
    logic        load;
    logic        ready;
    logic        frame_tick;
    logic [3:0]  AN;
    logic [6:0]  CA;
    logic        DP;

    int checks = 0;
    int fails  = 0;

    seven_seg_scan_ctrl #(
        .NUM_DIGITS      (4),
        .CLK_DIV         (16),
        .ANODE_ACTIVE_LOW(1'b1),
        .SEG_ACTIVE_LOW  (1'b1)
    ) dut (
        .clk        (clk),
        .clr        (clr),
        .digits     (digits),
        .dp         (dp),
        .blank      (blank),
        .lz_suppress(lz_suppress),
        .brightness (brightness),
        .load       (load),
        .ready      (ready),
        .frame_tick (frame_tick),
        .AN         (AN),
        .CA         (CA),
        .DP         (DP)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic wait_frame(output bit ok);
        int n;
        ok = 1'b0;
        n  = 0;
        while (!ok && n < 300) begin
            @(negedge clk);
            n++;
            if (frame_tick === 1'b1) ok = 1'b1;
        end
    endtask

    task automatic test_reset();
        int lit;
        clr = 1'b0; digits = '0; dp = '0; blank = '0; lz_suppress = 1'b0;
        brightness = 4'd15; load = 1'b0;
        #12;
        checks++; if (AN !== 4'b1111) begin fails++; $display("FAIL reset_an: got %b expected 1111", AN); end
        checks++; if (CA !== 7'b1111111) begin fails++; $display("FAIL reset_ca: got %b expected 1111111", CA); end
        checks++; if (DP !== 1'b1) begin fails++; $display("FAIL reset_dp: got %b expected 1", DP); end
        checks++; if (ready !== 1'b1) begin fails++; $display("FAIL reset_ready: got %b expected 1", ready); end
        checks++; if (frame_tick !== 1'b0) begin fails++; $display("FAIL reset_tick: got %b expected 0", frame_tick); end
        @(negedge clk);
        clr = 1'b1;
        lit = 0;
        repeat (20) begin
            @(negedge clk);
            if (AN !== 4'b1111) lit++;
        end
        checks++; if (lit !== 0) begin fails++; $display("FAIL reset_dark: lit cycles %0d expected 0", lit); end
    endtask

    task automatic test_scan();
        bit ok;
        int d;
        logic [3:0] an_exp [4];
        logic [6:0] ca_exp [4];
        logic       dp_exp [4];
        an_exp = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
        ca_exp = '{7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001};
        dp_exp = '{1'b1, 1'b1, 1'b0, 1'b1};
        digits = 16'h4321; dp = 4'b0100; blank = 4'b0000; lz_suppress = 1'b0; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        checks++; if (ready !== 1'b0) begin fails++; $display("FAIL scan_ready_low: got %b expected 0", ready); end
        wait_frame(ok);
        checks++; if (!ok) begin fails++; $display("FAIL scan_frame_wait: got timeout expected frame_tick"); end
        checks++; if (ready !== 1'b1) begin fails++; $display("FAIL scan_ready_high: got %b expected 1", ready); end
        for (int k = 1; k <= 64; k++) begin
            @(negedge clk);
            d = (k - 1) / 16;
            checks++; if (AN !== an_exp[d]) begin fails++; $display("FAIL scan_an k=%0d: got %b expected %b", k, AN, an_exp[d]); end
            checks++; if (CA !== ca_exp[d]) begin fails++; $display("FAIL scan_ca k=%0d: got %b expected %b", k, CA, ca_exp[d]); end
            checks++; if (DP !== dp_exp[d]) begin fails++; $display("FAIL scan_dp k=%0d: got %b expected %b", k, DP, dp_exp[d]); end
        end
    endtask

    task automatic test_lz();
        bit ok;
        int d;
        logic [3:0] an_exp [4];
        logic [6:0] ca_exp [4];
        an_exp = '{4'b1110, 4'b1101, 4'b1111, 4'b1111};
        ca_exp = '{7'b1000000, 7'b0010010, 7'b1111111, 7'b1111111};
        digits = 16'h0050; dp = 4'b0000; blank = 4'b0000; lz_suppress = 1'b1; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        checks++; if (ready !== 1'b0) begin fails++; $display("FAIL lz_ready_low: got %b expected 0", ready); end
        wait_frame(ok);
        checks++; if (!ok) begin fails++; $display("FAIL lz_frame_wait: got timeout expected frame_tick"); end
        for (int k = 1; k <= 64; k++) begin
            @(negedge clk);
            d = (k - 1) / 16;
            if ((k % 16) == 8) begin
                checks++; if (AN !== an_exp[d]) begin fails++; $display("FAIL lz_an d=%0d: got %b expected %b", d, AN, an_exp[d]); end
                checks++; if (CA !== ca_exp[d]) begin fails++; $display("FAIL lz_ca d=%0d: got %b expected %b", d, CA, ca_exp[d]); end
            end
        end
    endtask

    task automatic test_brightness();
        bit ok;
        int on0;
        int on1;
        logic [3:0] lvl [2];
        int         exp_on [2];
        lvl    = '{4'd3, 4'd0};
        exp_on = '{4, 1};
        for (int t = 0; t < 2; t++) begin
            brightness = lvl[t];
            wait_frame(ok);
            checks++; if (!ok) begin fails++; $display("FAIL bright_frame_wait: got timeout expected frame_tick"); end
            on0 = 0;
            on1 = 0;
            for (int k = 1; k <= 32; k++) begin
                @(negedge clk);
                if (k <= 16 && AN !== 4'b1111) on0++;
                if (k > 16 && AN !== 4'b1111) on1++;
            end
            checks++; if (on0 !== exp_on[t]) begin fails++; $display("FAIL bright%0d_digit0: got %0d lit cycles expected %0d", lvl[t], on0, exp_on[t]); end
            checks++; if (on1 !== exp_on[t]) begin fails++; $display("FAIL bright%0d_digit1: got %0d lit cycles expected %0d", lvl[t], on1, exp_on[t]); end
        end
        brightness = 4'd15;
    endtask

    task automatic test_back_to_back();
        bit ok;
        int d;
        logic [3:0] an_exp [4];
        logic [6:0] ca_exp [4];
        an_exp = '{4'b1110, 4'b1111, 4'b1011, 4'b0111};
        ca_exp = '{7'b0000011, 7'b1111111, 7'b0010000, 7'b0000000};
        repeat (2) @(negedge clk);
        digits = 16'h89AB; dp = 4'b0010; blank = 4'b0010; lz_suppress = 1'b0; load = 1'b1;
        @(negedge clk);
        digits = 16'hCDEF; dp = 4'b0000; blank = 4'b0000; load = 1'b1;
        checks++; if (ready !== 1'b0) begin fails++; $display("FAIL b2b_ready_low: got %b expected 0", ready); end
        @(negedge clk);
        load = 1'b0;
        checks++; if (ready !== 1'b0) begin fails++; $display("FAIL b2b_ready_still_low: got %b expected 0", ready); end
        wait_frame(ok);
        checks++; if (!ok) begin fails++; $display("FAIL b2b_frame_wait: got timeout expected frame_tick"); end
        checks++; if (ready !== 1'b1) begin fails++; $display("FAIL b2b_ready_high: got %b expected 1", ready); end
        for (int k = 1; k <= 64; k++) begin
            @(negedge clk);
            d = (k - 1) / 16;
            if ((k % 16) == 8) begin
                checks++; if (AN !== an_exp[d]) begin fails++; $display("FAIL b2b_an d=%0d: got %b expected %b", d, AN, an_exp[d]); end
                checks++; if (CA !== ca_exp[d]) begin fails++; $display("FAIL b2b_ca d=%0d: got %b expected %b", d, CA, ca_exp[d]); end
                checks++; if (DP !== 1'b1) begin fails++; $display("FAIL b2b_dp d=%0d: got %b expected 1", d, DP); end
            end
        end
    endtask

    task automatic test_load_at_wrap();
        bit ok;
        wait_frame(ok);
        checks++; if (!ok) begin fails++; $display("FAIL wrap_frame_wait: got timeout expected frame_tick"); end
        repeat (63) @(negedge clk);
        digits = 16'h5555; dp = 4'b0000; blank = 4'b0000; lz_suppress = 1'b0; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        checks++; if (frame_tick !== 1'b1) begin fails++; $display("FAIL wrap_tick: got %b expected 1", frame_tick); end
        checks++; if (ready !== 1'b0) begin fails++; $display("FAIL wrap_ready_low: got %b expected 0", ready); end
        for (int k = 1; k <= 72; k++) begin
            @(negedge clk);
            if (k == 8) begin
                checks++; if (CA !== 7'b0000011) begin fails++; $display("FAIL wrap_old_ca: got %b expected 0000011", CA); end
                checks++; if (ready !== 1'b0) begin fails++; $display("FAIL wrap_ready_mid: got %b expected 0", ready); end
            end
            if (k == 64) begin
                checks++; if (frame_tick !== 1'b1) begin fails++; $display("FAIL wrap_tick2: got %b expected 1", frame_tick); end
                checks++; if (ready !== 1'b1) begin fails++; $display("FAIL wrap_ready_high: got %b expected 1", ready); end
            end
            if (k == 72) begin
                checks++; if (CA !== 7'b0010010) begin fails++; $display("FAIL wrap_new_ca: got %b expected 0010010", CA); end
                checks++; if (AN !== 4'b1110) begin fails++; $display("FAIL wrap_new_an: got %b expected 1110", AN); end
            end
        end
    endtask

    task automatic test_reset_midslot();
        int lit;
        digits = 16'h1111; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (AN !== 4'b1110) begin fails++; $display("FAIL rst_pre_an: got %b expected 1110", AN); end
        #1;
        clr = 1'b0;
        #1;
        checks++; if (AN !== 4'b1111) begin fails++; $display("FAIL rst_mid_an: got %b expected 1111", AN); end
        checks++; if (CA !== 7'b1111111) begin fails++; $display("FAIL rst_mid_ca: got %b expected 1111111", CA); end
        checks++; if (DP !== 1'b1) begin fails++; $display("FAIL rst_mid_dp: got %b expected 1", DP); end
        checks++; if (ready !== 1'b1) begin fails++; $display("FAIL rst_mid_ready: got %b expected 1", ready); end
        @(negedge clk);
        clr = 1'b1;
        lit = 0;
        repeat (200) begin
            @(negedge clk);
            if (AN !== 4'b1111 || CA !== 7'b1111111) lit++;
        end
        checks++; if (lit !== 0) begin fails++; $display("FAIL rst_stays_dark: got %0d lit cycles expected 0", lit); end
        checks++; if (ready !== 1'b1) begin fails++; $display("FAIL rst_ready_after: got %b expected 1", ready); end
    endtask

    initial begin
        test_reset();
        test_scan();
        test_lz();
        test_brightness();
        test_back_to_back();
        test_load_at_wrap();
        test_reset_midslot();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/seven_seg_scan_ctrl.md
# seven_seg_scan_ctrl

Parametrised N-digit multiplexed seven-segment display controller: time-multiplexes `NUM_DIGITS` hex digits onto shared cathode lines with one-hot anode scanning, per-digit decimal point and blanking, leading-zero suppression and 16-level PWM brightness. Display data is double-buffered through a load/ready handshake and committed only at frame boundaries, so an update never tears mid-frame. The block sits between the board-level digit sources and the display pins, replacing the fixed four-digit driver.

## Interface
- `NUM_DIGITS`, 8: digits scanned; 2..16.
- `CLK_DIV`, 100000: clk cycles per digit slot; multiple of 16, ≥16.
- `ANODE_ACTIVE_LOW`, 1: 1 = selected anode driven 0.
- `SEG_ACTIVE_LOW`, 1: 1 = lit segment/DP driven 0.

- `clk` in 1: system clock, rising edge.
- `clr` in 1: reset, asynchronous assert, active-low.
- `digits` in 4*NUM_DIGITS: nibble i = digit i; digit 0 least significant (rightmost).
- `dp` in NUM_DIGITS: decimal point enable per digit.
- `blank` in NUM_DIGITS: 1 = digit dark.
- `lz_suppress` in 1: enable leading-zero suppression.
- `brightness` in 4: 0 dimmest, 15 full duty.
- `load` in 1: capture digits/dp/blank/lz_suppress into pending buffer.
- `ready` out 1: pending buffer empty, load accepted.
- `frame_tick` out 1: one-cycle pulse at each frame start.
- `AN` out NUM_DIGITS: anode drives.
- `CA` out 7: segments, bit order gfedcba.
- `DP` out 1: decimal point segment.

## Operation
- Registers: `slot_cnt` (0..CLK_DIV-1), `idx` (0..NUM_DIGITS-1), pending buffer + valid flag, active buffer.
- `slot_cnt` increments every cycle; at CLK_DIV-1 wraps to 0 and `idx` advances; `idx` wraps NUM_DIGITS-1 -> 0 (frame boundary).
- Handshake: load sampled when `ready`=1 -> pending captured, valid set. Load while `ready`=0 ignored (no overwrite). `brightness` is not buffered; sampled live.
- At frame boundary with valid=1: pending -> active, valid cleared, on the same edge `idx` becomes 0.
- Digit i dark if active blank[i], or lz_suppress active and digit i plus all more-significant digits are 0 (digit 0 never suppressed by LZ). DP follows dp[i] unless blank[i]; LZ suppression does not clear DP.
- PWM: digit lit only while `slot_cnt` < (brightness+1)*(CLK_DIV/16); otherwise all anodes inactive, segments off.
- Decode 0-F standard hex (b and d lowercase): 0 = abcdef, 1 = bc, 7 = abc, 8 = all, A = abcefg, F = aefg.
- Active-low params invert the respective outputs after decode; dark digit still drives its anode inactive.

## Timing
- Reset (`clr`=0, asynchronous): slot_cnt=0, idx=0, valid=0, active blank all 1, digits 0, dp 0, lz 0; outputs: AN all inactive, CA and DP all off, `ready`=1, `frame_tick`=0.
- AN/CA/DP registered: reflect idx/slot_cnt/active state of the previous cycle (1-cycle latency).
- `ready` falls the cycle after an accepted load; rises the cycle after commit.
- `frame_tick` registered: high for exactly the one cycle after idx wraps to 0.
- Load on the same cycle as a frame boundary: captured to pending, committed at the next boundary, not this one.
- Commit visible on AN/CA one cycle after the boundary edge (digit 0 slot onward).
- Reset mid-frame: pending data discarded, display dark until first load commits.
- brightness change takes effect on next cycle's comparison (may shorten/lengthen current slot).

## Test plan
- NUM_DIGITS=4, CLK_DIV=16, brightness=15; reset, load digits=16'h4321, blank=0 -> ready low 1 cycle after load; after next frame_tick AN scans 1110,1101,1011,0111 each 16 cycles; CA=1111001 (1) in digit-0 slot.
- lz_suppress=1, digits=16'h0050 -> digits 3,2 dark (AN stays 1111 in slots 2,3), digit 1 shows 5, digit 0 shows 0 (1000000).
- brightness=3 -> each slot anode active exactly 4 of 16 cycles; brightness=0 -> 1 cycle.
- Second load while ready=0 with different data -> ignored; first data displayed after commit; ready returns 1 one cycle after frame boundary.
- Load asserted in the wrap cycle -> old data shown for one full frame, new data from the following frame.
- Assert clr mid-slot -> outputs immediately all off/inactive, ready=1; after release display stays dark with no load.
